// File: rtl/odd_pipe_if.sv
// Shared opcode package and the operand/result bundle of the odd execution pipe.
//
// descriptions::opcode : decoded instruction classes the odd pipe understands.
// odd_pipe_if          : issue-side operands, local-store port and writeback port.
//   slave  modport : used by odd_pipe (operands/LS data in, results/LS requests out)
//   master modport : used by the issue stage / local store / testbench

package descriptions;

  typedef enum logic [4:0] {
    NOP                                   = 5'd0,
    SHIFT_LEFT_QUADWORD_BY_BITS           = 5'd1,
    SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE = 5'd2,
    SHIFT_LEFT_QUADWORD_BY_BYTES          = 5'd3,
    SHIFT_LEFT_QUADWORD_BY_BYTES_IMMEDIATE= 5'd4,
    ROTATE_QUADWORD_BY_BYTES              = 5'd5,
    ROTATE_QUADWORD_BY_BYTES_IMMEDIATE    = 5'd6,
    LOAD_QUADWORD_D_FORM                  = 5'd7,
    LOAD_QUADWORD_A_FORM                  = 5'd8,
    STORE_QUADWORD_D_FORM                 = 5'd9,
    STORE_QUADWORD_A_FORM                 = 5'd10,
    BRANCH_RELATIVE                       = 5'd11,
    BRANCH_ABSOLUTE                       = 5'd12,
    BRANCH_IF_ZERO_WORD                   = 5'd13,
    ADD_WORD                              = 5'd14
  } opcode;

endpackage

interface odd_pipe_if;
  import descriptions::*;

  opcode        op_input_op_code;
  logic [6:0]   I7_input;
  logic [9:0]   I10_input;
  logic [15:0]  I16_input;
  logic [17:0]  I18_input;
  logic [127:0] ra_input;
  logic [127:0] rb_input;
  logic [127:0] rc_input;
  logic [6:0]   rt_address_input;
  logic [31:0]  PC_input;
  logic [31:0]  PC_output;
  logic         branch_taken;
  logic [14:0]  LS_address_output;
  logic [127:0] LS_data_input;
  logic [127:0] LS_data_output;
  logic         LS_wr_en;
  logic [127:0] rt_value_output;
  logic [6:0]   rt_address_output;
  logic         wrt_en_output;

  modport slave (
    input  op_input_op_code, I7_input, I10_input, I16_input, I18_input,
           ra_input, rb_input, rc_input, rt_address_input, PC_input, LS_data_input,
    output PC_output, branch_taken, LS_address_output, LS_data_output, LS_wr_en,
           rt_value_output, rt_address_output, wrt_en_output
  );

  modport master (
    output op_input_op_code, I7_input, I10_input, I16_input, I18_input,
           ra_input, rb_input, rc_input, rt_address_input, PC_input, LS_data_input,
    input  PC_output, branch_taken, LS_address_output, LS_data_output, LS_wr_en,
           rt_value_output, rt_address_output, wrt_en_output
  );

endinterface

// File: rtl/odd_pipe.sv
// Odd execution pipe: quadword shift/rotate, local-store load/store and branch unit.
//
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, clears every register and output
//   bus   : odd_pipe_if.slave -- operands in, next PC / LS request / RF writeback out
//
// Operand bit 0 is the MSB, so the preferred slot (bits 0:31) is [127:96] here.
// Stage 1 computes the result; stages 2..LATENCY only carry {value, rt addr, wr en}.
// Load data arrives two cycles after issue and is merged into stage 3, so loads
// and permute ops share the same writeback latency. LATENCY must be at least 3.

module odd_pipe
  import descriptions::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic      clock,
  input  logic      reset,
  odd_pipe_if.slave bus
);

  localparam int unsigned LOAD_STAGE = 3;

  // Left shift by whole bytes; counts of 16 or more clear the quadword.
  function automatic logic [127:0] shl_bytes(input logic [127:0] x, input logic [4:0] n);
    logic [127:0] r;
    if (n[4]) begin
      r = 128'd0;
    end else begin
      r = x << {n[3:0], 3'b000};
    end
    return r;
  endfunction

  // Left rotate by whole bytes: upper half of the doubled operand after the shift.
  function automatic logic [127:0] rotl_bytes(input logic [127:0] x, input logic [3:0] n);
    logic [255:0] t;
    t = {x, x} << {n, 3'b000};
    return t[255:128];
  endfunction

  // Local-store addresses are quadword aligned: low four bits forced to zero.
  function automatic logic [14:0] ls_align(input logic [10:0] a);
    return {a, 4'b0000};
  endfunction

  logic [31:0]  d_addr_s;
  logic [31:0]  word_off_s;
  logic [31:0]  pc_plus4_s;
  logic [127:0] s1_val_s;
  logic [6:0]   s1_addr_s;
  logic         s1_we_s;
  logic         s1_load_s;
  logic [31:0]  pc_next_s;
  logic         taken_s;
  logic [14:0]  ls_addr_s;
  logic [127:0] ls_data_s;
  logic         ls_we_s;
  logic         unused_s;

  logic [127:0] val_r  [1:LATENCY];
  logic [6:0]   addr_r [1:LATENCY];
  logic         we_r   [1:LATENCY];
  logic         load1_r;
  logic         load2_r;
  logic [31:0]  pc_r;
  logic         taken_r;
  logic [14:0]  ls_addr_r;
  logic [127:0] ls_data_r;
  logic         ls_we_r;

  // D-form address: preferred slot of ra plus quadword displacement.
  assign d_addr_s   = bus.ra_input[127:96] + {{18{bus.I10_input[9]}}, bus.I10_input, 4'b0000};
  // Word-scaled I16: A-form address and branch offset/target share this term.
  assign word_off_s = {{14{bus.I16_input[15]}}, bus.I16_input, 2'b00};
  assign pc_plus4_s = bus.PC_input + 32'd4;

  // Bits that the odd pipe deliberately never looks at.
  assign unused_s = ^{bus.I18_input, bus.rb_input[127:101], bus.rb_input[95:0],
                      d_addr_s[31:15], d_addr_s[3:0]};

  // Stage-1 decode and compute for every op class.
  always_comb begin
    s1_val_s  = 128'd0;
    s1_addr_s = 7'd0;
    s1_we_s   = 1'b0;
    s1_load_s = 1'b0;
    pc_next_s = pc_plus4_s;
    taken_s   = 1'b0;
    ls_addr_s = 15'd0;
    ls_data_s = 128'd0;
    ls_we_s   = 1'b0;
    case (bus.op_input_op_code)
      SHIFT_LEFT_QUADWORD_BY_BITS: begin
        s1_val_s  = bus.ra_input << bus.rb_input[98:96];
        s1_addr_s = bus.rt_address_input;
        s1_we_s   = 1'b1;
      end
      SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE: begin
        s1_val_s  = bus.ra_input << bus.I7_input[2:0];
        s1_addr_s = bus.rt_address_input;
        s1_we_s   = 1'b1;
      end
      SHIFT_LEFT_QUADWORD_BY_BYTES: begin
        s1_val_s  = shl_bytes(bus.ra_input, bus.rb_input[100:96]);
        s1_addr_s = bus.rt_address_input;
        s1_we_s   = 1'b1;
      end
      SHIFT_LEFT_QUADWORD_BY_BYTES_IMMEDIATE: begin
        s1_val_s  = shl_bytes(bus.ra_input, bus.I7_input[4:0]);
        s1_addr_s = bus.rt_address_input;
        s1_we_s   = 1'b1;
      end
      ROTATE_QUADWORD_BY_BYTES: begin
        s1_val_s  = rotl_bytes(bus.ra_input, bus.rb_input[99:96]);
        s1_addr_s = bus.rt_address_input;
        s1_we_s   = 1'b1;
      end
      ROTATE_QUADWORD_BY_BYTES_IMMEDIATE: begin
        s1_val_s  = rotl_bytes(bus.ra_input, bus.I7_input[3:0]);
        s1_addr_s = bus.rt_address_input;
        s1_we_s   = 1'b1;
      end
      LOAD_QUADWORD_D_FORM: begin
        s1_addr_s = bus.rt_address_input;
        s1_we_s   = 1'b1;
        s1_load_s = 1'b1;
        ls_addr_s = ls_align(d_addr_s[14:4]);
      end
      LOAD_QUADWORD_A_FORM: begin
        s1_addr_s = bus.rt_address_input;
        s1_we_s   = 1'b1;
        s1_load_s = 1'b1;
        ls_addr_s = ls_align(word_off_s[14:4]);
      end
      STORE_QUADWORD_D_FORM: begin
        ls_addr_s = ls_align(d_addr_s[14:4]);
        ls_data_s = bus.rc_input;
        ls_we_s   = 1'b1;
      end
      STORE_QUADWORD_A_FORM: begin
        ls_addr_s = ls_align(word_off_s[14:4]);
        ls_data_s = bus.rc_input;
        ls_we_s   = 1'b1;
      end
      BRANCH_RELATIVE: begin
        pc_next_s = bus.PC_input + word_off_s;
        taken_s   = 1'b1;
      end
      BRANCH_ABSOLUTE: begin
        pc_next_s = word_off_s;
        taken_s   = 1'b1;
      end
      BRANCH_IF_ZERO_WORD: begin
        if (bus.rc_input[127:96] == 32'd0) begin
          pc_next_s = bus.PC_input + word_off_s;
          taken_s   = 1'b1;
        end else begin
          pc_next_s = pc_plus4_s;
          taken_s   = 1'b0;
        end
      end
      default: begin
        s1_val_s = 128'd0;
      end
    endcase
  end

  // Result pipeline; for loads the local-store data becomes the value entering stage 3.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 1; i <= LATENCY; i++) begin
        val_r[i]  <= 128'd0;
        addr_r[i] <= 7'd0;
        we_r[i]   <= 1'b0;
      end
      load1_r <= 1'b0;
      load2_r <= 1'b0;
    end else begin
      val_r[1]  <= s1_val_s;
      addr_r[1] <= s1_addr_s;
      we_r[1]   <= s1_we_s;
      load1_r   <= s1_load_s;
      load2_r   <= load1_r;
      for (int unsigned i = 2; i <= LATENCY; i++) begin
        if ((i == LOAD_STAGE) && load2_r) begin
          val_r[i] <= bus.LS_data_input;
        end else begin
          val_r[i] <= val_r[i-1];
        end
        addr_r[i] <= addr_r[i-1];
        we_r[i]   <= we_r[i-1];
      end
    end
  end

  // Next-PC and local-store request registers, one cycle after issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_r      <= 32'd0;
      taken_r   <= 1'b0;
      ls_addr_r <= 15'd0;
      ls_data_r <= 128'd0;
      ls_we_r   <= 1'b0;
    end else begin
      pc_r      <= pc_next_s;
      taken_r   <= taken_s;
      ls_addr_r <= ls_addr_s;
      ls_data_r <= ls_data_s;
      ls_we_r   <= ls_we_s;
    end
  end

  assign bus.PC_output         = pc_r;
  assign bus.branch_taken      = taken_r;
  assign bus.LS_address_output = ls_addr_r;
  assign bus.LS_data_output    = ls_data_r;
  assign bus.LS_wr_en          = ls_we_r;
  assign bus.rt_value_output   = val_r[LATENCY];
  assign bus.rt_address_output = addr_r[LATENCY];
  assign bus.wrt_en_output     = we_r[LATENCY];

endmodule

// File: tb/tb_odd_pipe.sv
// Self-checking bench for odd_pipe: directed cases then random instructions,
// compared against a behavioural model built from the instruction rules.
// The bench also plays the local store, returning a fixed pattern per address.

module tb_odd_pipe;
  import descriptions::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  odd_pipe_if bus();

  odd_pipe dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    opcode        op;
    logic [6:0]   i7;
    logic [9:0]   i10;
    logic [15:0]  i16;
    logic [127:0] ra;
    logic [127:0] rb;
    logic [127:0] rc;
    logic [6:0]   rta;
    logic [31:0]  pc;
  } instr_t;

  typedef struct {
    logic [127:0] val;
    logic [6:0]   addr;
    logic         we;
  } rt_exp_t;

  rt_exp_t     rt_q[$];
  logic [14:0] ahist0 = 15'd0;
  logic [14:0] ahist1 = 15'd0;

  function automatic logic [31:0] pref(input logic [127:0] x);
    return x[127:96];
  endfunction

  // Local-store contents: a fixed function of the address.
  function automatic logic [127:0] mem_fn(input logic [14:0] a);
    logic [31:0] w;
    if (a == 15'h120) return 128'hDEAD;
    w = ({17'd0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    return {w, ~w, w ^ 32'hDEADBEEF, w + 32'd1};
  endfunction

  function automatic instr_t base(input opcode op);
    instr_t t;
    t.op = op; t.i7 = 7'd0; t.i10 = 10'd0; t.i16 = 16'd0;
    t.ra = 128'd0; t.rb = 128'd0; t.rc = 128'd0; t.rta = 7'd0; t.pc = 32'd0;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected effects of one instruction, straight from the instruction rules.
  function automatic void model(input instr_t t, output logic [31:0] pc_o, output logic tk,
                                output logic mem, output logic [14:0] la, output logic swe,
                                output logic [127:0] sd, output rt_exp_t r);
    logic [31:0] a;
    int n;
    pc_o = t.pc + 32'd4; tk = 1'b0; mem = 1'b0; la = 15'd0; swe = 1'b0; sd = 128'd0;
    r.val = 128'd0; r.addr = t.rta; r.we = 1'b0;
    a = 32'd0;
    case (t.op)
      SHIFT_LEFT_QUADWORD_BY_BITS: begin
        r.we = 1'b1; r.val = t.ra << (pref(t.rb) % 8);
      end
      SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE: begin
        r.we = 1'b1; r.val = t.ra << (t.i7 % 8);
      end
      SHIFT_LEFT_QUADWORD_BY_BYTES, SHIFT_LEFT_QUADWORD_BY_BYTES_IMMEDIATE: begin
        n = (t.op == SHIFT_LEFT_QUADWORD_BY_BYTES) ? int'(pref(t.rb) % 32) : int'(t.i7 % 32);
        r.we = 1'b1; r.val = (n > 15) ? 128'd0 : (t.ra << (8 * n));
      end
      ROTATE_QUADWORD_BY_BYTES, ROTATE_QUADWORD_BY_BYTES_IMMEDIATE: begin
        n = (t.op == ROTATE_QUADWORD_BY_BYTES) ? int'(pref(t.rb) % 16) : int'(t.i7 % 16);
        r.we = 1'b1; r.val = (t.ra << (8 * n)) | (t.ra >> (128 - 8 * n));
      end
      LOAD_QUADWORD_D_FORM, LOAD_QUADWORD_A_FORM, STORE_QUADWORD_D_FORM, STORE_QUADWORD_A_FORM: begin
        if (t.op == LOAD_QUADWORD_D_FORM || t.op == STORE_QUADWORD_D_FORM)
          a = pref(t.ra) + 32'($signed(t.i10)) * 32'd16;
        else
          a = 32'($signed(t.i16)) * 32'd4;
        mem = 1'b1;
        la  = a[14:0] & 15'h7FF0;
        if (t.op == LOAD_QUADWORD_D_FORM || t.op == LOAD_QUADWORD_A_FORM) begin
          r.we = 1'b1; r.val = mem_fn(la);
        end else begin
          swe = 1'b1; sd = t.rc;
        end
      end
      BRANCH_RELATIVE: begin
        pc_o = t.pc + 32'($signed(t.i16)) * 32'd4; tk = 1'b1;
      end
      BRANCH_ABSOLUTE: begin
        pc_o = 32'($signed(t.i16)) * 32'd4; tk = 1'b1;
      end
      BRANCH_IF_ZERO_WORD: begin
        if (pref(t.rc) == 32'd0) begin
          pc_o = t.pc + 32'($signed(t.i16)) * 32'd4; tk = 1'b1;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic drive(input instr_t t);
    bus.op_input_op_code = t.op;
    bus.I7_input = t.i7; bus.I10_input = t.i10; bus.I16_input = t.i16;
    bus.I18_input = 18'($urandom);
    bus.ra_input = t.ra; bus.rb_input = t.rb; bus.rc_input = t.rc;
    bus.rt_address_input = t.rta; bus.PC_input = t.pc;
  endtask

  task automatic clear_model();
    rt_exp_t z;
    z.val = 128'd0; z.addr = 7'd0; z.we = 1'b0;
    rt_q.delete();
    for (int i = 0; i < 3; i++) rt_q.push_back(z);
    ahist0 = 15'd0; ahist1 = 15'd0;
  endtask

  // Issue one instruction, advance one clock and check everything due now.
  task automatic step(input instr_t t);
    logic [31:0]  epc;
    logic         etk, emem, eswe;
    logic [14:0]  ela;
    logic [127:0] esd;
    rt_exp_t      e, got;
    drive(t);
    bus.LS_data_input = mem_fn(ahist1);
    model(t, epc, etk, emem, ela, eswe, esd, e);
    rt_q.push_back(e);
    @(posedge clock); #1;
    chk("pc_output", 128'(bus.PC_output), 128'(epc));
    chk("branch_taken", 128'(bus.branch_taken), 128'(etk));
    chk("ls_wr_en", 128'(bus.LS_wr_en), 128'(eswe));
    if (emem) chk("ls_address", 128'(bus.LS_address_output), 128'(ela));
    if (eswe) chk("ls_data", bus.LS_data_output, esd);
    got = rt_q.pop_front();
    chk("wrt_en", 128'(bus.wrt_en_output), 128'(got.we));
    if (got.we) begin
      chk("rt_value", bus.rt_value_output, got.val);
      chk("rt_address", 128'(bus.rt_address_output), 128'(got.addr));
    end
    ahist1 = ahist0;
    ahist0 = bus.LS_address_output;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pc"}, 128'(bus.PC_output), 128'd0);
    chk({tag, "_taken"}, 128'(bus.branch_taken), 128'd0);
    chk({tag, "_ls_addr"}, 128'(bus.LS_address_output), 128'd0);
    chk({tag, "_ls_data"}, bus.LS_data_output, 128'd0);
    chk({tag, "_ls_wr_en"}, 128'(bus.LS_wr_en), 128'd0);
    chk({tag, "_rt_value"}, bus.rt_value_output, 128'd0);
    chk({tag, "_rt_addr"}, 128'(bus.rt_address_output), 128'd0);
    chk({tag, "_wrt_en"}, 128'(bus.wrt_en_output), 128'd0);
  endtask

  initial begin
    instr_t t;
    drive(base(NOP));
    bus.LS_data_input = 128'd0;

    // Power-on reset.
    @(posedge clock); @(posedge clock); #1;
    check_all_zero("reset");
    #2 reset = 1'b1;
    clear_model();

    // Bit shifts, including a zero count and a back-to-back immediate form.
    t = base(SHIFT_LEFT_QUADWORD_BY_BITS); t.ra = 128'd20; t.rb = {32'd2, 96'd0}; t.rta = 7'd5;
    step(t);
    t = base(SHIFT_LEFT_QUADWORD_BY_BITS); t.ra = 128'd20; t.rb = 128'd10; t.rta = 7'd6;
    step(t);
    t = base(SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE); t.i7 = 7'd5; t.ra = 128'd15; t.rta = 7'd7;
    step(t);
    // Byte rotate wrapping the top byte to the bottom, byte shift past 15.
    t = base(ROTATE_QUADWORD_BY_BYTES_IMMEDIATE); t.i7 = 7'd1; t.ra = 128'h01 << 120; t.rta = 7'd8;
    step(t);
    t = base(SHIFT_LEFT_QUADWORD_BY_BYTES); t.ra = ~128'd0; t.rb = {32'd16, 96'd0}; t.rta = 7'd9;
    step(t);
    t = base(SHIFT_LEFT_QUADWORD_BY_BYTES_IMMEDIATE); t.ra = ~128'd0; t.i7 = 7'd15; t.rta = 7'd10;
    step(t);
    // Loads and stores.
    t = base(LOAD_QUADWORD_D_FORM); t.ra = {32'h100, 96'd0}; t.i10 = 10'd2; t.rta = 7'd11;
    step(t);
    t = base(LOAD_QUADWORD_A_FORM); t.i16 = 16'hFFF3; t.rta = 7'd12;
    step(t);
    t = base(STORE_QUADWORD_D_FORM); t.ra = {32'h7FFF, 96'd0}; t.i10 = 10'h3FF;
    t.rc = {4{32'hCAFEF00D}};
    step(t);
    t = base(STORE_QUADWORD_A_FORM); t.i16 = 16'h0105; t.rc = 128'h1234;
    step(t);
    // Branches.
    t = base(BRANCH_RELATIVE); t.pc = 32'h40; t.i16 = 16'hFFFC;
    step(t);
    t = base(BRANCH_IF_ZERO_WORD); t.pc = 32'h40; t.i16 = 16'hFFFC; t.rc = {32'd1, 96'd0};
    step(t);
    t = base(BRANCH_IF_ZERO_WORD); t.pc = 32'h40; t.i16 = 16'h0010; t.rc = {32'd0, 96'hFF};
    step(t);
    t = base(BRANCH_ABSOLUTE); t.pc = 32'h80; t.i16 = 16'h8001;
    step(t);
    t = base(ADD_WORD); t.pc = 32'hFFFF_FFFC; t.ra = 128'd3; t.rta = 7'd13;
    step(t);

    // Random instruction stream.
    for (int k = 0; k < 400; k++) begin
      t = base(opcode'(5'($urandom_range(0, 14))));
      t.i7 = 7'($urandom); t.i10 = 10'($urandom); t.i16 = 16'($urandom);
      t.ra = {$urandom, $urandom, $urandom, $urandom};
      t.rb = {$urandom, $urandom, $urandom, $urandom};
      t.rc = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 0) t.rc[127:96] = 32'd0;
      t.rta = 7'($urandom);
      t.pc = $urandom & 32'hFFFF_FFFC;
      step(t);
    end
    for (int k = 0; k < 3; k++) step(base(NOP));

    // Reset asserted mid-stream: outputs clear at once, in-flight ops never write.
    t = base(SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE); t.ra = 128'd1; t.i7 = 7'd3; t.rta = 7'd20;
    step(t);
    t = base(LOAD_QUADWORD_A_FORM); t.i16 = 16'h0040; t.rta = 7'd21;
    step(t);
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    @(posedge clock); #2 reset = 1'b1;
    clear_model();
    for (int k = 0; k < 5; k++) step(base(NOP));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
